// File: rtl/npu_pkg.sv
// Shared convolution-datapath constants and the window feeder state type.
package npu_pkg;

    localparam int DEF_IMG_H = 16;
    localparam int DEF_IMG_W = 15;
    localparam int DEF_K_H   = 3;
    localparam int DEF_K_W   = 3;
    localparam int DEF_DW    = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } feeder_state_e;

endpackage

// File: rtl/conv_window_feeder_line_buffer.sv
// One image row of pixel storage; read is combinational so the old value at
// addr is available in the same cycle it is overwritten.
module line_buffer #(
    parameter int DEPTH = 15,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream in, vertical K_H-pixel columns out, with window-complete
// flags for the conv core's image circular register.
module conv_window_feeder
    import npu_pkg::*;
#(
    parameter int IMG_H = DEF_IMG_H,
    parameter int IMG_W = DEF_IMG_W,
    parameter int K_H   = DEF_K_H,
    parameter int K_W   = DEF_K_W,
    parameter int DW    = DEF_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [K_H*DW-1:0]        out_col,
    output logic                     out_win_valid,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_cidx,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] R_FILL_LAST = RW'(K_H - 2);
    localparam logic [RW-1:0] R_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] C_WIN_FIRST = CW'(K_W - 1);

    feeder_state_e state, state_next;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          last_taken;
    logic          accept;
    logic [K_H*DW-1:0] col_next;
    logic [DW-1:0] lb_rd [K_H-1];

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Once out_valid rises it and all out_* hold until out_ready; in_ready is
    // combinational so a drain and a new accept may share one cycle.
    assign in_ready = (state == S_FILL || state == S_STREAM) && !last_taken
                      && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < K_H - 1; i++) begin : g_lb
        logic [DW-1:0] wdata;
        if (i == K_H - 2) begin : g_top
            assign wdata = in_pixel;
        end else begin : g_mid
            assign wdata = lb_rd[i+1];
        end
        line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (c),
            .wdata (wdata),
            .rdata (lb_rd[i])
        );
    end

    always_comb begin
        col_next = '0;
        for (int i = 0; i < K_H - 1; i++) begin
            col_next[i*DW +: DW] = lb_rd[i];
        end
        col_next[(K_H-1)*DW +: DW] = in_pixel;
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        unique case (state)
            S_IDLE:   if (start) state_next = S_FILL;
            S_FILL:   if (accept && r == R_FILL_LAST && c == C_LAST) state_next = S_STREAM;
            S_STREAM: if (out_valid && out_ready && out_last) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            r             <= '0;
            c             <= '0;
            last_taken    <= 1'b0;
            out_valid     <= 1'b0;
            out_col       <= '0;
            out_win_valid <= 1'b0;
            out_row       <= '0;
            out_cidx      <= '0;
            out_last      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_IDLE) begin
                r          <= '0;
                c          <= '0;
                last_taken <= 1'b0;
            end else if (accept) begin
                if (c == C_LAST) begin
                    c <= '0;
                    if (r == R_LAST) begin
                        last_taken <= 1'b1;
                    end else begin
                        r <= r + 1'b1;
                    end
                end else begin
                    c <= c + 1'b1;
                end
            end
            if (accept && state == S_STREAM) begin
                out_valid     <= 1'b1;
                out_col       <= col_next;
                out_win_valid <= (c >= C_WIN_FIRST);
                out_row       <= r;
                out_cidx      <= c;
                out_last      <= (r == R_LAST) && (c == C_LAST);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: ramp frames under free-flow, random
// stalls, mid-frame start, and mid-frame reset followed by a fresh frame.
module tb_conv_window_feeder;

    localparam int IMG_H = 16;
    localparam int IMG_W = 15;
    localparam int K_H   = 3;
    localparam int DW    = 8;
    localparam int NPIX  = IMG_H * IMG_W;
    localparam int BUDGET = 5000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DW-1:0]    in_pixel = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [K_H*DW-1:0] out_col;
    logic             out_win_valid;
    logic [3:0]       out_row;
    logic [3:0]       out_cidx;
    logic             out_last;
    logic             busy;
    logic             frame_done;

    int n_checks = 0;
    int n_errors = 0;
    logic [33:0] exp_q[$];

    conv_window_feeder dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixel      (in_pixel),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_col       (out_col),
        .out_win_valid (out_win_valid),
        .out_row       (out_row),
        .out_cidx      (out_cidx),
        .out_last      (out_last),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ramp(input int r, input int c);
        return 8'((r * IMG_W + c) % 256);
    endfunction

    function automatic logic [33:0] pack_out();
        return {out_col, out_row, out_cidx, out_win_valid, out_last};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_col"}, out_col, 0);
        check({tag, "_flags"}, {out_win_valid, out_last, frame_done, busy, in_ready}, 0);
        check({tag, "_row_cidx"}, {out_row, out_cidx}, 0);
    endtask

    task automatic run_frame(input bit rnd, input bit mid_start, input bit abort75);
        int p, cols, wins, cyc;
        bit seen_last, hold_v, pend;
        logic [33:0] hold, e;
        exp_q.delete();
        for (int r = K_H - 1; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                exp_q.push_back({ramp(r, c), ramp(r - 1, c), ramp(r - 2, c), 4'(r), 4'(c),
                                 1'(c >= 2), 1'(r == IMG_H - 1 && c == IMG_W - 1)});
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        p = 0; cols = 0; wins = 0; cyc = 0;
        seen_last = 0; hold_v = 0; pend = 0; hold = '0;
        while (!seen_last && cyc < BUDGET) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (p < NPIX) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            in_pixel  = ramp(p / IMG_W, p % IMG_W);
            start     = mid_start && (p == 100);
            #1;
            if (abort75 && out_valid && out_row == 4'd7 && out_cidx == 4'd5) begin
                check("abort_col_7_5", out_col, {ramp(7, 5), ramp(6, 5), ramp(5, 5)});
                rst = 1'b1; start = 1'b0; in_valid = 1'b0;
                @(negedge clk);
                check_reset_outputs("rst_mid");
                rst = 1'b0;
                return;
            end
            if (pend) check("latency", out_valid, 1);
            pend = 0;
            if (hold_v) check("stall_hold", pack_out(), hold);
            hold_v = out_valid && !out_ready;
            hold = pack_out();
            if (!rnd) check("in_ready_level", in_ready, (p < NPIX));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_col", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("col", pack_out(), e);
                end
                if (cols == 0) check("first_col", {out_col, out_win_valid}, {24'h1E0F00, 1'b0});
                if (out_row == 4'd2 && out_cidx == 4'd2)
                    check("col_2_2", {out_col, out_win_valid}, {24'h201102, 1'b1});
                if (out_last) begin
                    check("last_col", {out_col, out_row, out_cidx}, {24'hEFE0D1, 4'd15, 4'd14});
                    seen_last = 1;
                end
                cols++;
                if (out_win_valid) wins++;
            end
            if (in_valid && in_ready) begin
                if (p / IMG_W >= K_H - 1) pend = 1;
                p++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("frame_finished", seen_last, 1);
        #1;
        check("frame_done_pulse", {frame_done, busy}, 2'b11);
        check("col_count", cols, 210);
        check("win_count", wins, 182);
        check("pix_count", p, NPIX);
        check("exp_q_empty", exp_q.size(), 0);
        @(negedge clk);
        #1;
        check("frame_done_end", {frame_done, busy, in_ready}, 3'b000);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle_in_ready", {in_ready, busy}, 2'b00);
        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b1, 1'b1, 1'b0);
        run_frame(1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
